// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order core control blocks.
package ooo_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int ROB_IDX_W = 6;
  localparam int ALLOC_W   = 4;
  localparam int COMMIT_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } rob_ctrl_state_t;

endpackage

// File: rtl/rob_ptr_add.sv
// Modular ROB pointer advance by a small increment (0..4).
// The wrap comes for free from truncating to IDX_W bits.
module rob_ptr_add
  import ooo_pkg::*;
#(
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic [IDX_W-1:0] ptr,
  input  logic [2:0]       inc,
  output logic [IDX_W-1:0] sum
);

  assign sum = ptr + IDX_W'(inc);

endmodule

// File: rtl/rob_alloc_commit_ctrl.sv
// Reorder-buffer index sequencer: in-order allocation grants, in-order
// retirement of up to two ready entries, and tail restore on a flush.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | first cycle out of reset; no grants, no commits
// RUN     | normal operation; allocate and commit
// RECOVER | one-cycle squash window after a flush; no grants, no commits
module rob_alloc_commit_ctrl
  import ooo_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [2:0]                     alloc_req,
  output logic                           alloc_ok,
  output logic [ALLOC_W*ROB_IDX_W-1:0]   alloc_idx,
  input  logic [COMMIT_W-1:0]            head_ready,
  output logic [COMMIT_W-1:0]            commit_en,
  output logic [ROB_IDX_W-1:0]           commit_idx0,
  output logic [ROB_IDX_W-1:0]           commit_idx1,
  input  logic                           flush,
  input  logic [ROB_IDX_W-1:0]           flush_idx,
  output logic [ROB_IDX_W-1:0]           rob_head,
  output logic [ROB_IDX_W:0]             rob_count,
  output logic                           rob_full,
  output logic                           rob_empty,
  output logic                           busy_recover
);

  localparam int                CNT_W     = ROB_IDX_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(ROB_DEPTH);

  rob_ctrl_state_t        state_q, state_d;
  logic [ROB_IDX_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]       count_q;

  logic [ROB_IDX_W-1:0]   head_next, tail_alloc, flush_tail, flush_dist;
  logic [ROB_IDX_W-1:0]   slot [ALLOC_W];
  logic [CNT_W-1:0]       free_slots;
  logic [1:0]             ncommit;
  logic                   run;

  assign run        = (state_q == RUN);
  assign free_slots = DEPTH_CNT - count_q;
  assign ncommit    = {1'b0, commit_en[0]} + {1'b0, commit_en[1]};
  assign flush_dist = flush_idx - head_q;

  // Allocation slots A..D sit MSB-first: slot A (the current tail) in the top field.
  for (genvar i = 0; i < ALLOC_W; i++) begin : g_slot
    rob_ptr_add #(.IDX_W(ROB_IDX_W)) u_slot_add (
      .ptr (tail_q),
      .inc (3'(i)),
      .sum (slot[i])
    );
    assign alloc_idx[(ALLOC_W-1-i)*ROB_IDX_W +: ROB_IDX_W] = slot[i];
  end

  rob_ptr_add #(.IDX_W(ROB_IDX_W)) u_tail_add (
    .ptr (tail_q),
    .inc (alloc_req),
    .sum (tail_alloc)
  );

  rob_ptr_add #(.IDX_W(ROB_IDX_W)) u_head_add (
    .ptr (head_q),
    .inc ({1'b0, ncommit}),
    .sum (head_next)
  );

  rob_ptr_add #(.IDX_W(ROB_IDX_W)) u_head1_add (
    .ptr (head_q),
    .inc (3'd1),
    .sum (commit_idx1)
  );

  rob_ptr_add #(.IDX_W(ROB_IDX_W)) u_flush_add (
    .ptr (flush_idx),
    .inc (3'd1),
    .sum (flush_tail)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the combinational grant and commit decisions.
  // Free space looks only at the registered count; same-cycle commits are not
  // credited so the grant path stays short.
  always_comb begin
    state_d   = state_q;
    alloc_ok  = 1'b0;
    commit_en = '0;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (flush) state_d = RECOVER;
      RECOVER: state_d = flush ? RECOVER : RUN;
      default: state_d = IDLE;
    endcase
    alloc_ok = run && !flush && (alloc_req != 3'd0) && (alloc_req <= 3'd4)
               && (CNT_W'(alloc_req) <= free_slots);
    commit_en[0] = run && (count_q != '0) && head_ready[0];
    commit_en[1] = commit_en[0] && (count_q > CNT_W'(1)) && head_ready[1];
  end

  // Head, tail and occupancy. A flush rebuilds count from the distance between
  // head and the branch, still honouring commits of older entries this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_next;
      if (flush && (state_q != IDLE)) begin
        tail_q  <= flush_tail;
        count_q <= {1'b0, flush_dist} + CNT_W'(1) - CNT_W'(ncommit);
      end else if (alloc_ok) begin
        tail_q  <= tail_alloc;
        count_q <= count_q + CNT_W'(alloc_req) - CNT_W'(ncommit);
      end else begin
        count_q <= count_q - CNT_W'(ncommit);
      end
    end
  end

  assign commit_idx0  = head_q;
  assign rob_head     = head_q;
  assign rob_count    = count_q;
  assign rob_full     = (count_q == DEPTH_CNT);
  assign rob_empty    = (count_q == '0);
  assign busy_recover = (state_q == RECOVER);

endmodule

// File: tb/tb_rob_alloc_commit_ctrl.sv
// Bench for rob_alloc_commit_ctrl: directed scenarios followed by random
// traffic, checked against a queue-of-indices model of the ROB.
module tb_rob_alloc_commit_ctrl;
  import ooo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  alloc_req = '0;
  logic        alloc_ok;
  logic [23:0] alloc_idx;
  logic [1:0]  head_ready = '0;
  logic [1:0]  commit_en;
  logic [5:0]  commit_idx0, commit_idx1;
  logic        flush = 1'b0;
  logic [5:0]  flush_idx = '0;
  logic [5:0]  rob_head;
  logic [6:0]  rob_count;
  logic        rob_full, rob_empty, busy_recover;

  rob_alloc_commit_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_ok     (alloc_ok),
    .alloc_idx    (alloc_idx),
    .head_ready   (head_ready),
    .commit_en    (commit_en),
    .commit_idx0  (commit_idx0),
    .commit_idx1  (commit_idx1),
    .flush        (flush),
    .flush_idx    (flush_idx),
    .rob_head     (rob_head),
    .rob_count    (rob_count),
    .rob_full     (rob_full),
    .rob_empty    (rob_empty),
    .busy_recover (busy_recover)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        ok;
    logic [1:0]  cen;
    logic [5:0]  c0, c1, head;
    logic [6:0]  cnt;
    logic        full, empty, busy;
    logic [23:0] aidx;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Reference model: the ROB as a queue of occupied indices, oldest first.
  int   m_phase = 0;  // 0 = just out of reset, 1 = running, 2 = squash window
  int   m_head = 0;
  int   rob_q[$];

  task automatic step(input logic r, input int req, input logic [1:0] hr,
                      input logic fl, input int fidx);
    exp_t e;
    int   sz, nc, pos, keep, old_tail;
    logic run;
    @(posedge clk);
    #1;
    cyc++;
    rst_n      = r;
    alloc_req  = req[2:0];
    head_ready = hr;
    flush      = fl;
    flush_idx  = fidx[5:0];
    if (!r) begin
      m_phase = 0;
      m_head  = 0;
      rob_q.delete();
    end
    sz       = rob_q.size();
    old_tail = (m_head + sz) % 64;
    run      = r && (m_phase == 1);
    e.cyc    = cyc;
    e.ok     = run && !fl && req >= 1 && req <= 4 && req <= 64 - sz;
    e.cen[0] = run && sz >= 1 && hr[0];
    e.cen[1] = e.cen[0] && sz >= 2 && hr[1];
    e.c0     = 6'(m_head);
    e.c1     = 6'((m_head + 1) % 64);
    e.head   = 6'(m_head);
    e.cnt    = 7'(sz);
    e.full   = (sz == 64);
    e.empty  = (sz == 0);
    e.busy   = r && (m_phase == 2);
    for (int i = 0; i < 4; i++) e.aidx[(3-i)*6 +: 6] = 6'((old_tail + i) % 64);
    expq.push_back(e);
    if (r) begin
      nc = int'(e.cen[0]) + int'(e.cen[1]);
      if (fl && m_phase != 0) begin
        pos = -1;
        foreach (rob_q[k]) if (rob_q[k] == fidx) pos = k;
        assert (pos >= 0 && pos + 1 >= nc)
          else $error("bench drove flush_idx %0d outside the live window", fidx);
        keep = pos + 1 - nc;
        for (int i = 0; i < nc; i++) void'(rob_q.pop_front());
        while (rob_q.size() > keep) void'(rob_q.pop_back());
      end else begin
        for (int i = 0; i < nc; i++) void'(rob_q.pop_front());
        if (e.ok) for (int i = 0; i < req; i++) rob_q.push_back((old_tail + i) % 64);
      end
      m_head = (m_head + nc) % 64;
      if (m_phase == 0)      m_phase = 1;
      else if (fl)           m_phase = 2;
      else                   m_phase = 1;
    end
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // Monitor: pops the expectation for the current cycle and compares.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("alloc_ok",     e.cyc, 32'(alloc_ok),     32'(e.ok));
      chk("alloc_idx",    e.cyc, 32'(alloc_idx),    32'(e.aidx));
      chk("commit_en",    e.cyc, 32'(commit_en),    32'(e.cen));
      chk("commit_idx0",  e.cyc, 32'(commit_idx0),  32'(e.c0));
      chk("commit_idx1",  e.cyc, 32'(commit_idx1),  32'(e.c1));
      chk("rob_head",     e.cyc, 32'(rob_head),     32'(e.head));
      chk("rob_count",    e.cyc, 32'(rob_count),    32'(e.cnt));
      chk("rob_full",     e.cyc, 32'(rob_full),     32'(e.full));
      chk("rob_empty",    e.cyc, 32'(rob_empty),    32'(e.empty));
      chk("busy_recover", e.cyc, 32'(busy_recover), 32'(e.busy));
    end
  end

  initial begin
    int req, fidx, k;
    logic [1:0] hr;
    logic fl;

    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 0);                       // IDLE cycle
    for (int i = 0; i < 15; i++) step(1, 4, 2'b00, 0, 0);
    step(1, 2, 2'b00, 0, 0);                       // count 62
    step(1, 3, 2'b00, 0, 0);                       // denied: only 2 free
    step(1, 2, 2'b00, 0, 0);                       // granted, full
    step(1, 4, 2'b00, 0, 0);                       // denied: full
    for (int i = 0; i < 31; i++) step(1, 0, 2'b11, 0, 0);  // head 62, count 2
    step(1, 1, 2'b01, 0, 0);                       // head 63, count 2
    step(1, 0, 2'b11, 0, 0);                       // commit 63 and 0 across wrap
    step(1, 4, 2'b00, 0, 0);
    step(1, 1, 2'b00, 0, 0);                       // count 5
    step(1, 0, 2'b10, 0, 0);                       // head not ready: nothing retires
    for (int i = 0; i < 6; i++) step(1, 4, 2'b00, 0, 0);   // tail 30
    for (int i = 0; i < 4; i++) step(1, 0, 2'b11, 0, 0);
    step(1, 0, 2'b01, 0, 0);                       // head 10, count 20
    step(1, 0, 2'b01, 1, 14);                      // flush with older commit
    step(1, 4, 2'b00, 0, 0);                       // RECOVER: no grant
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 4, 2'b00, 0, 0);   // count 20
    step(1, 0, 2'b00, 1, 30);                      // flush keeps all 20
    step(0, 4, 2'b11, 0, 0);                       // reset mid-RECOVER
    step(0, 0, 2'b00, 0, 0);
    step(1, 4, 2'b00, 0, 0);                       // IDLE: no grant
    for (int i = 0; i < 16; i++) step(1, 4, 2'b00, 0, 0);  // full again
    step(1, 4, 2'b00, 0, 0);                       // 17th denied

    for (int n = 0; n < 3000; n++) begin
      req  = int'($urandom_range(0, 5));
      hr   = 2'($urandom_range(0, 3));
      fl   = 1'b0;
      fidx = 0;
      if (m_phase != 0 && rob_q.size() > 0 && $urandom_range(0, 11) == 0) begin
        k    = int'($urandom_range(0, rob_q.size() - 1));
        fidx = rob_q[k];
        fl   = 1'b1;
        if (k == 0) hr[1] = 1'b0;
      end
      if ($urandom_range(0, 399) == 0) begin
        step(0, req, hr, 1'b0, 0);
        step(1, 0, 2'b00, 1'b0, 0);
      end else begin
        step(1, req, hr, fl, fidx);
      end
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
